result_drain: RTL and testbench

Output stage downstream of the systolic matrix multiplier. It snapshots the packed result bus (all S×S result elements, M bits each) on a start pulse, then streams the elements out one per transfer over a valid/ready handshake, tagged with row and column indices. This frees the array to start the next multiplication while the previous result is being read out.

---
 rtl/result_drain.sv | 124 ++++++++++++
 tb/tb_result_drain.sv | 279 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/result_drain.sv
// Snapshot-and-stream output stage for the systolic multiplier result bus.
// Define RESULT_DRAIN_TRANSPOSE_EN to stream in column-major order instead of row-major.
module result_drain #(
    parameter int N = 2,
    parameter int S = 4,
    parameter int M = 5,
    localparam int IW = $clog2(S)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [M*S*S-1:0]  data_in,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [M-1:0]      out_data,
    output logic [IW-1:0]     out_row,
    output logic [IW-1:0]     out_col,
    output logic              out_last,
    output logic              busy,
    output logic              done,
    output logic              dropped
);

    // N only exists for parameter-list parity with the array; sanity-check the set anyway.
    if (S < 2 || N < 1) begin : g_param_check
        $error("result_drain: S must be >= 2 and N >= 1");
    end

    typedef enum logic [0:0] {StIdle, StDrain} state_e;

    localparam logic [IW-1:0] MaxIdx = IW'(S - 1);

    state_e           state_q;
    logic [M*S*S-1:0] snap_q;
    logic [IW-1:0]    row_q, col_q;
    logic [IW-1:0]    row_nx, col_nx;
    logic             done_q, dropped_q;
    logic             xfer, at_end;
    int unsigned      elem_idx;

    always_comb begin
        at_end = (row_q == MaxIdx) && (col_q == MaxIdx);
        xfer   = (state_q == StDrain) && out_ready;
    end

    always_comb begin
        row_nx = row_q;
        col_nx = col_q;
`ifdef RESULT_DRAIN_TRANSPOSE_EN
        if (row_q == MaxIdx) begin
            row_nx = '0;
            col_nx = col_q + IW'(1);
        end else begin
            row_nx = row_q + IW'(1);
        end
`else
        if (col_q == MaxIdx) begin
            col_nx = '0;
            row_nx = row_q + IW'(1);
        end else begin
            col_nx = col_q + IW'(1);
        end
`endif
    end

    always_comb begin
        elem_idx = int'(row_q) * S + int'(col_q);
        out_data = snap_q[M*elem_idx +: M];
    end

    assign out_valid = (state_q == StDrain);
    assign busy      = (state_q == StDrain);
    assign out_row   = row_q;
    assign out_col   = col_q;
    assign out_last  = at_end;
    assign done      = done_q;
    assign dropped   = dropped_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= StIdle;
            snap_q    <= '0;
            row_q     <= '0;
            col_q     <= '0;
            done_q    <= 1'b0;
            dropped_q <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                StIdle: begin
                    if (start) begin
                        snap_q  <= data_in;
                        row_q   <= '0;
                        col_q   <= '0;
                        state_q <= StDrain;
                    end
                end
                StDrain: begin
                    if (xfer && at_end) begin
                        // Final beat: a coincident start is taken with no idle bubble.
                        done_q <= 1'b1;
                        row_q  <= '0;
                        col_q  <= '0;
                        if (start) begin
                            snap_q <= data_in;
                        end else begin
                            state_q <= StIdle;
                        end
                    end else begin
                        if (xfer) begin
                            row_q <= row_nx;
                            col_q <= col_nx;
                        end
                        if (start) begin
                            dropped_q <= 1'b1;
                        end
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

endmodule

// File: tb/tb_result_drain.sv
// Self-checking bench for result_drain: table-driven basic drain plus directed
// back-pressure, back-to-back, rejected-start and async-reset sequences.
module tb_result_drain;

    localparam int S  = 4;
    localparam int M  = 5;
    localparam int IW = 2;

    logic             clk = 1'b0;
    logic             rst = 1'b0;
    logic             start = 1'b0;
    logic             out_ready = 1'b0;
    logic [M*S*S-1:0] data_in = '0;
    logic             out_valid;
    logic [M-1:0]     out_data;
    logic [IW-1:0]    out_row;
    logic [IW-1:0]    out_col;
    logic             out_last;
    logic             busy;
    logic             done;
    logic             dropped;

    int n_checks = 0;
    int n_fail   = 0;

    result_drain #(.N(2), .S(S), .M(M)) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .data_in   (data_in),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_row   (out_row),
        .out_col   (out_col),
        .out_last  (out_last),
        .busy      (busy),
        .done      (done),
        .dropped   (dropped)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [M*S*S-1:0] mat(input bit inv);
        logic [M*S*S-1:0] m;
        int v;
        m = '0;
        for (int i = 0; i < S; i++) begin
            for (int j = 0; j < S; j++) begin
                v = 4 * i + j;
                if (inv) v = 31 - v;
                m[M*(i*S+j) +: M] = v[M-1:0];
            end
        end
        return m;
    endfunction

    function automatic int beat_row(input int k);
`ifdef RESULT_DRAIN_TRANSPOSE_EN
        return k % S;
`else
        return k / S;
`endif
    endfunction

    function automatic int beat_col(input int k);
`ifdef RESULT_DRAIN_TRANSPOSE_EN
        return k / S;
`else
        return k % S;
`endif
    endfunction

    function automatic int beat_val(input bit inv, input int k);
        int v;
        v = 4 * beat_row(k) + beat_col(k);
        return inv ? 31 - v : v;
    endfunction

    task automatic check_beat(input string tag, input bit inv, input int k);
        chk({tag, ".valid"}, 32'(out_valid), 32'd1);
        chk({tag, ".data"},  32'(out_data),  32'(beat_val(inv, k)));
        chk({tag, ".row"},   32'(out_row),   32'(beat_row(k)));
        chk({tag, ".col"},   32'(out_col),   32'(beat_col(k)));
        chk({tag, ".last"},  32'(out_last),  32'(k == S * S - 1));
    endtask

    typedef struct {
        bit start;
        bit ready;
        bit valid;
        int data;
        int row;
        int col;
        bit last;
        bit done;
        bit busy;
    } vec_t;

    vec_t tbl[18];
    bit   bp_pat[4] = '{1'b1, 1'b0, 1'b0, 1'b1};

    initial begin
        int k;
        int p;

        // Basic drain table: record i is the state seen just after edge i.
        for (int i = 0; i < 16; i++) begin
            tbl[i] = '{start: (i == 0), ready: 1'b1, valid: 1'b1, data: beat_val(0, i),
                       row: beat_row(i), col: beat_col(i), last: (i == 15),
                       done: 1'b0, busy: 1'b1};
        end
        tbl[16] = '{start: 1'b0, ready: 1'b1, valid: 1'b0, data: 0, row: 0, col: 0,
                    last: 1'b0, done: 1'b1, busy: 1'b0};
        tbl[17] = '{start: 1'b0, ready: 1'b1, valid: 1'b0, data: 0, row: 0, col: 0,
                    last: 1'b0, done: 1'b0, busy: 1'b0};

        // Reset state, with start and data present to prove reset dominates.
        data_in   = mat(0);
        start     = 1'b1;
        out_ready = 1'b1;
        step();
        step();
        chk("rst.valid",   32'(out_valid), 32'd0);
        chk("rst.busy",    32'(busy),      32'd0);
        chk("rst.done",    32'(done),      32'd0);
        chk("rst.dropped", 32'(dropped),   32'd0);
        chk("rst.last",    32'(out_last),  32'd0);
        chk("rst.row",     32'(out_row),   32'd0);
        chk("rst.col",     32'(out_col),   32'd0);
        chk("rst.data",    32'(out_data),  32'd0);
        start = 1'b0;
        rst   = 1'b1;
        step();
        chk("idle.valid", 32'(out_valid), 32'd0);

        for (int i = 0; i < 18; i++) begin
            start     = tbl[i].start;
            out_ready = tbl[i].ready;
            step();
            chk("tbl.valid", 32'(out_valid), 32'(tbl[i].valid));
            chk("tbl.busy",  32'(busy),      32'(tbl[i].busy));
            chk("tbl.done",  32'(done),      32'(tbl[i].done));
            if (tbl[i].valid) begin
                chk("tbl.data", 32'(out_data), 32'(tbl[i].data));
                chk("tbl.row",  32'(out_row),  32'(tbl[i].row));
                chk("tbl.col",  32'(out_col),  32'(tbl[i].col));
                chk("tbl.last", 32'(out_last), 32'(tbl[i].last));
            end
        end
        start = 1'b0;

        // Back-pressure: ready pattern 1,0,0,1 repeating; outputs must hold while stalled.
        data_in   = mat(0);
        start     = 1'b1;
        out_ready = 1'b0;
        step();
        start = 1'b0;
        k = 0;
        p = 0;
        while (k < S * S && p < 200) begin
            check_beat("bp", 0, k);
            out_ready = bp_pat[p % 4];
            p++;
            step();
            if (out_ready) k++;
        end
        chk("bp.completed", 32'(k), 32'(S * S));
        chk("bp.done",  32'(done),      32'd1);
        chk("bp.valid", 32'(out_valid), 32'd0);
        out_ready = 1'b0;
        step();

        // Back-to-back: new start on the final-transfer cycle, no bubble.
        data_in   = mat(0);
        start     = 1'b1;
        out_ready = 1'b1;
        step();
        for (int i = 0; i < S * S; i++) begin
            check_beat("b2b.a", 0, i);
            chk("b2b.a.done", 32'(done), 32'd0);
            if (i == S * S - 1) begin
                start   = 1'b1;
                data_in = mat(1);
            end else begin
                start = 1'b0;
            end
            step();
        end
        start = 1'b0;
        for (int i = 0; i < S * S; i++) begin
            check_beat("b2b.b", 1, i);
            chk("b2b.b.done", 32'(done), 32'(i == 0));
            chk("b2b.busy",   32'(busy), 32'd1);
            step();
        end
        chk("b2b.end.done",    32'(done),      32'd1);
        chk("b2b.end.valid",   32'(out_valid), 32'd0);
        chk("b2b.dropped",     32'(dropped),   32'd0);
        step();
        chk("b2b.end.done2",   32'(done),      32'd0);

        // Rejected start at beat 5: remaining beats still from the original matrix.
        data_in = mat(0);
        start   = 1'b1;
        step();
        for (int i = 0; i < S * S; i++) begin
            check_beat("rej", 0, i);
            chk("rej.dropped", 32'(dropped), 32'(i > 5));
            if (i == 5) begin
                start   = 1'b1;
                data_in = mat(1);
            end else begin
                start = 1'b0;
            end
            step();
        end
        chk("rej.done",     32'(done),      32'd1);
        chk("rej.valid",    32'(out_valid), 32'd0);
        chk("rej.dropped2", 32'(dropped),   32'd1);
        step();
        chk("rej.dropped3", 32'(dropped),   32'd1);

        // Async reset at beat 8: outputs clear without waiting for a clock edge.
        data_in = mat(0);
        start   = 1'b1;
        step();
        start = 1'b0;
        for (int i = 0; i < 8; i++) step();
        check_beat("ar.pre", 0, 8);
        #2;
        rst = 1'b0;
        #1;
        chk("ar.valid",   32'(out_valid), 32'd0);
        chk("ar.busy",    32'(busy),      32'd0);
        chk("ar.done",    32'(done),      32'd0);
        chk("ar.row",     32'(out_row),   32'd0);
        chk("ar.col",     32'(out_col),   32'd0);
        chk("ar.data",    32'(out_data),  32'd0);
        chk("ar.dropped", 32'(dropped),   32'd0);
        #2;
        rst = 1'b1;
        step();
        chk("ar.idle.done",  32'(done),      32'd0);
        chk("ar.idle.valid", 32'(out_valid), 32'd0);
        data_in = mat(1);
        start   = 1'b1;
        step();
        start = 1'b0;
        for (int i = 0; i < S * S; i++) begin
            check_beat("ar.post", 1, i);
            step();
        end
        chk("ar.post.done", 32'(done), 32'd1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
